msg_entry_loader: RTL

Builds a scrolling-display message from board switches and offers it to the HEX scroller stage over a valid/ready handshake. An operator sets a 4-bit character code on `char_in` and presses an "enter" pushbutton to append it. A "commit" pushbutton presents the finished six-code message on `msg_codes`. The scroller loads it in place of its reset-time message and decodes each code onto HEX5..HEX0.

---
 rtl/msg_entry_loader_pkg.sv | 31 +++
 rtl/msg_entry_loader_if.sv | 21 ++
 rtl/msg_entry_loader_debounce.sv | 58 +++++
 rtl/msg_entry_loader.sv | 95 +++++++++
 4 files changed

// File: rtl/msg_entry_loader_pkg.sv
// Shared message-entry types and constants.
// Code values are common with the HEX scroller decoder.
package msg_pkg;

   localparam int MSG_LEN = 6;
   localparam int CODE_W  = 4;
   localparam int CNT_W   = 3;
   localparam int MSG_W   = MSG_LEN * CODE_W;

   localparam logic [CODE_W-1:0] CODE_BLANK = 4'h0;
   localparam logic [CODE_W-1:0] CODE_ONE   = 4'h1;
   localparam logic [CODE_W-1:0] CODE_D     = 4'hD;
   localparam logic [CODE_W-1:0] CODE_E     = 4'hE;

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(MSG_LEN);

   typedef enum logic {
      ENTRY,
      OFFER
   } state_t;

   typedef logic [MSG_LEN-1:0][CODE_W-1:0] slots_t;

   // Left-most digit fills first: slot index for the next write.
   function automatic logic [CNT_W-1:0] slot_of(
      input logic [CNT_W-1:0] cnt
   );
      return CNT_W'(MSG_LEN - 1) - cnt;
   endfunction

endpackage

// File: rtl/msg_entry_loader_if.sv
// Message offer channel from the entry loader to the scroller.
// valid/ready handshake carrying six packed character codes.
interface msg_entry_loader_if;

   logic                      msg_valid;
   logic                      msg_ready;
   logic [msg_pkg::MSG_W-1:0] msg_codes;

   modport master (
      output msg_valid,
      output msg_codes,
      input  msg_ready
   );

   modport slave (
      input  msg_valid,
      input  msg_codes,
      output msg_ready
   );

endinterface

// File: rtl/msg_entry_loader_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, run-length debouncer,
// and a one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          w_diff;
   logic          w_flip;

   assign w_diff = r_sync2 ^ r_level;
   assign w_flip = w_diff && (r_cnt == LAST);

   // Bring the raw button into the clock domain; idle is released.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing samples; flip level at the limit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_press <= w_flip && r_level;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/msg_entry_loader.sv
// Switch-driven message builder feeding the HEX scroller.
// Enter appends char_in left to right; commit offers the message.
module msg_entry_loader
   import msg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  enter_n,
   input  logic                  commit_n,
   input  logic [CODE_W-1:0]     char_in,
   msg_entry_loader_if.master    msg,
   output logic [CNT_W-1:0]      count,
   output logic                  full
);

   state_t             r_state;
   slots_t             r_slots;
   logic [CNT_W-1:0]   r_count;
   logic               r_full;
   logic               r_valid;

   logic               w_enter_evt;
   logic               w_commit_evt;
   logic               w_wr;
   logic [CNT_W-1:0]   w_cnt_post;
   logic [CNT_W-1:0]   w_slot;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_enter_db (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_btn_n (enter_n),
      .o_press (w_enter_evt)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_commit_db (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_btn_n (commit_n),
      .o_press (w_commit_evt)
   );

   // Enter write resolves first so a same-cycle commit sees it.
   assign w_wr       = w_enter_evt && (r_count != LEN_C);
   assign w_cnt_post = r_count + CNT_W'(w_wr);
   assign w_slot     = slot_of(r_count);

   // Entry/offer FSM with the message buffer and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ENTRY;
         r_slots <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ENTRY: begin
               if (w_wr) begin
                  r_slots[w_slot] <= char_in;
                  r_count         <= w_cnt_post;
                  r_full          <= (w_cnt_post == LEN_C);
               end
               if (w_commit_evt && (w_cnt_post != '0)) begin
                  r_state <= OFFER;
                  r_valid <= 1'b1;
               end
            end
            OFFER: begin
               if (r_valid && msg.msg_ready) begin
                  r_slots <= {MSG_LEN{CODE_BLANK}};
                  r_count <= '0;
                  r_full  <= 1'b0;
                  r_valid <= 1'b0;
                  r_state <= ENTRY;
               end
            end
            default: begin
               r_state <= ENTRY;
            end
         endcase
      end
   end

   assign msg.msg_valid = r_valid;
   assign msg.msg_codes = r_slots;
   assign count         = r_count;
   assign full          = r_full;

endmodule
